// File: rtl/cgol_pkg.sv
// Shared types for the Game-of-Life generation engine.
package cgol_pkg;

    localparam int ROWS = 8;

    typedef logic [7:0] row_t;
    typedef logic [2:0] raddr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        SWAP    = 2'd2
    } gen_state_t;

    // Neighbour row indices; 3-bit arithmetic wraps naturally, edges are masked by the caller.
    function automatic raddr_t row_above(input raddr_t r);
        return r - 3'd1;
    endfunction

    function automatic raddr_t row_below(input raddr_t r);
        return r + 3'd1;
    endfunction

endpackage

// File: rtl/cgol_board_buf.sv
// Double-buffered 8x8 board: front bank feeds display and neighbour reads,
// back bank collects the next generation; swap flips the roles in one edge.
module cgol_board_buf
    import cgol_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   we,
    input  logic   wfront,     // 1: write front bank (load), 0: write back bank (compute)
    input  raddr_t waddr,
    input  row_t   wdata,
    input  logic   swap,
    input  raddr_t raddr_a,
    input  raddr_t raddr_m,
    input  raddr_t raddr_b,
    input  raddr_t disp_addr,
    output row_t   rd_a,
    output row_t   rd_m,
    output row_t   rd_b,
    output row_t   disp_row
);

    row_t bank0 [ROWS];
    row_t bank1 [ROWS];
    logic sel;      // 0: bank0 is front, 1: bank1 is front
    logic wbank;

    assign wbank = wfront ? sel : ~sel;

    // Bank 0 storage, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) bank0[i] <= '0;
        end else if (we && !wbank) begin
            bank0[waddr] <= wdata;
        end
    end

    // Bank 1 storage, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) bank1[i] <= '0;
        end else if (we && wbank) begin
            bank1[waddr] <= wdata;
        end
    end

    // Front/back select; toggling it publishes the whole new board at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       sel <= 1'b0;
        else if (swap) sel <= ~sel;
    end

    assign rd_a     = sel ? bank1[raddr_a]   : bank0[raddr_a];
    assign rd_m     = sel ? bank1[raddr_m]   : bank0[raddr_m];
    assign rd_b     = sel ? bank1[raddr_b]   : bank0[raddr_b];
    assign disp_row = sel ? bank1[disp_addr] : bank0[disp_addr];

endmodule

// File: rtl/cgol_gen_engine.sv
// Game-of-Life generation sequencer: walks rows 0..7 through the external
// combinational decoder, fills the back buffer, then swaps.
// Build option: define CGOL_VWRAP_EN for a vertical torus (row 0 sees row 7
// above, row 7 sees row 0 below); otherwise the border above/below is dead.
module cgol_gen_engine
    import cgol_pkg::*;
#(
    parameter int GEN_PERIOD = 512,
    parameter int GEN_W      = 8
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             load_en,
    input  logic [2:0]       load_addr,
    input  logic [7:0]       load_row,
    input  logic             step,
    input  logic             run,
    output logic [7:0]       row_in,
    output logic [7:0]       row_a,
    output logic [7:0]       row_b,
    input  logic [7:0]       row_out,
    input  logic [2:0]       disp_addr,
    output logic [7:0]       disp_row,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count
);

    localparam int            PW    = $clog2(GEN_PERIOD);
    localparam logic [PW-1:0] PLAST = PW'(GEN_PERIOD - 1);

    gen_state_t        state, state_nx;
    raddr_t            r;
    logic [PW-1:0]     pcnt;
    logic [GEN_W-1:0]  gcnt;
    logic              go;
    logic              in_idle, in_comp, in_swap;
    logic              top_ok, bot_ok;
    row_t              rd_a, rd_m, rd_b;

    assign in_idle = (state == IDLE);
    assign in_comp = (state == COMPUTE);
    assign in_swap = (state == SWAP);

    // A manual step and an expiring auto-period in the same cycle start a single generation.
    assign go = step || (run && (pcnt == PLAST));

    // State register.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: one pass over the rows, then a single swap cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = COMPUTE;
            COMPUTE: if (r == 3'd7) state_nx = SWAP;
            SWAP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Row index advances only while computing; parked at 0 otherwise.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset)        r <= '0;
        else if (in_comp) r <= r + 3'd1;
        else              r <= '0;
    end

    // Auto-step period counter: counts idle cycles while run is held.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset)                     pcnt <= '0;
        else if (!run || (in_idle && go)) pcnt <= '0;
        else if (in_idle)              pcnt <= pcnt + PW'(1);
    end

    // Completed-generation counter, bumped as the swap lands.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset)        gcnt <= '0;
        else if (in_swap) gcnt <= gcnt + GEN_W'(1);
    end

    assign gen_count = gcnt;
    assign busy      = !in_idle;

`ifdef CGOL_VWRAP_EN
    assign top_ok = 1'b1;
    assign bot_ok = 1'b1;
`else
    assign top_ok = (r != 3'd0);
    assign bot_ok = (r != 3'd7);
`endif

    cgol_board_buf u_buf (
        .clk       (ph1),
        .rst       (reset),
        .we        ((in_idle && load_en) || in_comp),
        .wfront    (in_idle),
        .waddr     (in_comp ? r : load_addr),
        .wdata     (in_comp ? row_out : load_row),
        .swap      (in_swap),
        .raddr_a   (row_above(r)),
        .raddr_m   (r),
        .raddr_b   (row_below(r)),
        .disp_addr (disp_addr),
        .rd_a      (rd_a),
        .rd_m      (rd_m),
        .rd_b      (rd_b),
        .disp_row  (disp_row)
    );

    // Decoder-facing rows are driven only during COMPUTE, with edge rows masked.
    always_comb begin
        row_in = '0;
        row_a  = '0;
        row_b  = '0;
        if (in_comp) begin
            row_in = rd_m;
            if (top_ok) row_a = rd_a;
            if (bot_ok) row_b = rd_b;
        end
    end

endmodule
